// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one column at a time, debounces a single
// pressed key and its release, and reports the key index with a valid pulse.
module module_keypad_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV) + 1;
   localparam int BW = $clog2(DEBOUNCE_CNT) + 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        r_state, w_state;
   logic [3:0]    r_rs1, r_rs2;
   logic [3:0]    r_col, w_col;
   logic [DW-1:0] r_dwell, w_dwell;
   logic [BW-1:0] r_deb, w_deb;
   logic [1:0]    r_row_idx, w_row_idx;
   logic [1:0]    r_col_idx, w_col_idx;
   logic [3:0]    r_key_code, w_key_code;
   logic          r_key_valid, w_key_valid;
   logic          r_key_held, w_key_held;

   logic          w_rs_onehot;
   logic [3:0]    w_row_mask;
   logic [3:0]    w_col_rot;

   function automatic logic [1:0] f_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   assign w_rs_onehot = (r_rs2 != 4'd0) && ((r_rs2 & (r_rs2 - 4'd1)) == 4'd0);
   assign w_row_mask  = 4'b0001 << r_row_idx;
   assign w_col_rot   = {r_col[2:0], r_col[3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SCAN;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_col       <= 4'b0001;
         r_dwell     <= '0;
         r_deb       <= '0;
         r_row_idx   <= '0;
         r_col_idx   <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_rs1       <= row;
         r_rs2       <= r_rs1;
         r_col       <= w_col;
         r_dwell     <= w_dwell;
         r_deb       <= w_deb;
         r_row_idx   <= w_row_idx;
         r_col_idx   <= w_col_idx;
         r_key_code  <= w_key_code;
         r_key_valid <= w_key_valid;
         r_key_held  <= w_key_held;
      end
   end

   // Dwell counter only runs in SCAN; it restarts at zero whenever SCAN is re-entered.
   always_comb begin
      w_state     = r_state;
      w_col       = r_col;
      w_dwell     = '0;
      w_deb       = r_deb;
      w_row_idx   = r_row_idx;
      w_col_idx   = r_col_idx;
      w_key_code  = r_key_code;
      w_key_valid = 1'b0;
      w_key_held  = r_key_held;
      case (r_state)
         SCAN: begin
            if (r_dwell == DWELL_LAST) begin
               if (w_rs_onehot) begin
                  w_row_idx = f_idx(r_rs2);
                  w_col_idx = f_idx(r_col);
                  w_deb     = '0;
                  w_state   = DEBOUNCE;
               end else begin
                  w_col = w_col_rot;
               end
            end else begin
               w_dwell = r_dwell + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (r_rs2 == w_row_mask) begin
               if (r_deb == DEB_LAST) begin
                  w_key_code  = {r_row_idx, r_col_idx};
                  w_key_valid = 1'b1;
                  w_key_held  = 1'b1;
                  w_state     = HELD;
               end else begin
                  w_deb = r_deb + BW'(1);
               end
            end else begin
               w_col   = w_col_rot;
               w_state = SCAN;
            end
         end
         HELD: begin
            if (!r_rs2[r_row_idx]) begin
               w_deb   = '0;
               w_state = RELEASE;
            end
         end
         RELEASE: begin
            if (!r_rs2[r_row_idx]) begin
               if (r_deb == DEB_LAST) begin
                  w_key_held = 1'b0;
                  w_col      = w_col_rot;
                  w_state    = SCAN;
               end else begin
                  w_deb = r_deb + BW'(1);
               end
            end else begin
               w_state = HELD;
            end
         end
         default: w_state = SCAN;
      endcase
   end

   assign col       = r_col;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Bench for module_keypad_scan with a combinational keypad model; key_valid
// pulses are checked by a monitor against a queue of expected key codes.
module tb_module_keypad_scan;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   // key[4r+c] connects col[c] to row[r]
   always_comb begin
      row = '0;
      for (int r = 0; r < 4; r++) begin
         row[r] = |(keys[4*r +: 4] & col);
      end
   end

   module_keypad_scan #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_held(input int budget, input string name);
      int n;
      n = 0;
      while (key_held !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, key_held}, 32'd1);
   endtask

   task automatic wait_col(input logic [3:0] want, input logic eq, input int budget);
      int n;
      n = 0;
      while (((col == want) != eq) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_col", {31'd0, (col == want)}, {31'd0, eq});
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && key_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_key_valid actual=code %0d expected=no pulse", key_code);
         end else begin
            check("key_code_on_valid", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            check("held_with_valid", {31'd0, key_held}, 32'd1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;
      int changes;
      logic [3:0] prev;

      // 1: reset values and free-running scan
      keys  = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_col", {28'd0, col}, 32'h1);
      check("reset_code", {28'd0, key_code}, 32'd0);
      check("reset_valid", {31'd0, key_valid}, 32'd0);
      check("reset_held", {31'd0, key_held}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("scan_col", {28'd0, col}, 32'd1 << ((i / 4) % 4));
         @(negedge clk);
      end

      // 2: hold key 6 for 60 cycles
      exp_q.push_back(4'd6);
      p0 = pulses;
      keys[6] = 1'b1;
      repeat (60) @(negedge clk);
      check("press6_held", {31'd0, key_held}, 32'd1);
      check("press6_col", {28'd0, col}, 32'h4);
      check("press6_code", {28'd0, key_code}, 32'd6);
      check("press6_pulses", pulses - p0, 32'd1);
      keys = '0;
      repeat (12) @(negedge clk);
      check("release6_held", {31'd0, key_held}, 32'd0);

      // 3: 3-cycle glitch on key 9 while column 1 is strobed
      wait_col(4'b0010, 1'b0, 20);
      wait_col(4'b0010, 1'b1, 20);
      p0 = pulses;
      keys[9] = 1'b1;
      repeat (3) @(negedge clk);
      keys[9] = 1'b0;
      repeat (4) @(negedge clk);
      check("glitch9_col", {28'd0, col}, 32'h4);
      check("glitch9_held", {31'd0, key_held}, 32'd0);
      check("glitch9_pulses", pulses - p0, 32'd0);

      // 4: two keys on one column never resolve to one row
      p0 = pulses;
      keys[1] = 1'b1;
      keys[5] = 1'b1;
      repeat (8) @(negedge clk);
      changes = 0;
      prev = col;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (col != prev) changes++;
         prev = col;
      end
      check("dual_col_changes", changes, 32'd4);
      check("dual_held", {31'd0, key_held}, 32'd0);
      check("dual_pulses", pulses - p0, 32'd0);
      keys = '0;
      repeat (8) @(negedge clk);

      // 5: short release bounce then full release
      exp_q.push_back(4'd6);
      p0 = pulses;
      keys[6] = 1'b1;
      wait_held(40, "bounce6_accept");
      repeat (4) @(negedge clk);
      keys[6] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bounce6_held_low", {31'd0, key_held}, 32'd1);
      end
      keys[6] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("bounce6_held_back", {31'd0, key_held}, 32'd1);
      end
      check("bounce6_pulses", pulses - p0, 32'd1);
      keys[6] = 1'b0;
      repeat (12) @(negedge clk);
      check("rel6_held", {31'd0, key_held}, 32'd0);
      check("rel6_col", {28'd0, col}, 32'h8);
      check("rel6_code", {28'd0, key_code}, 32'd6);

      // 6: reset while key 15 is held, then press it again
      exp_q.push_back(4'd15);
      keys[15] = 1'b1;
      wait_held(40, "press15_accept");
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst15_col", {28'd0, col}, 32'h1);
      check("rst15_held", {31'd0, key_held}, 32'd0);
      check("rst15_code", {28'd0, key_code}, 32'd0);
      check("rst15_valid", {31'd0, key_valid}, 32'd0);
      keys = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      exp_q.push_back(4'd15);
      keys[15] = 1'b1;
      wait_held(40, "repress15_accept");
      repeat (2) @(negedge clk);
      check("repress15_code", {28'd0, key_code}, 32'd15);
      keys = '0;
      repeat (12) @(negedge clk);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
